// File: rtl/adc_fe_pkg.sv
// Shared types and helpers for the ADC feature framer.
// State encoding, channel index width and sample quantization.
package adc_fe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CONVERT,
    WAIT,
    PRESENT
  } state_t;

  localparam int FEAT_MAX = 8;
  localparam int IDX_W    = $clog2(FEAT_MAX);
  localparam int RAW_W    = 16;

  // Keep the top bits of a raw sample: plain truncation, no rounding.
  function automatic logic [RAW_W-1:0] quantize(
    input logic [RAW_W-1:0] raw,
    input int               shift
  );
    return raw >> shift;
  endfunction

endpackage

// File: rtl/adc_fe_timer.sv
// Loadable down-counter with zero flag.
// Shared by the settle delay and the conversion timeout.
module adc_fe_timer
  import adc_fe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/adc_feature_framer.sv
// Sequences a shared ADC over N_FEAT channels into a packed feature frame.
// Define OVERSAMPLE_AVG_EN to convert each channel twice and average.
module adc_feature_framer
  import adc_fe_pkg::*;
#(
  parameter int N_FEAT      = 6,
  parameter int IN_W        = 4,
  parameter int ADC_W       = 8,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  output logic [2:0]             o_adc_sel,
  output logic                   o_adc_conv,
  input  logic                   i_adc_done,
  input  logic [ADC_W-1:0]       i_adc_data,
  output logic [N_FEAT*IN_W-1:0] o_feat_vec,
  output logic                   o_feat_valid,
  input  logic                   i_feat_ready,
  output logic                   o_busy,
  output logic                   o_timeout_err
);

  localparam int CNT_MAX =
    (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD =
    CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LD =
    CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(N_FEAT - 1);
  localparam int Q_SHIFT = ADC_W - IN_W;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [IDX_W-1:0]            r_idx;
  logic [N_FEAT-1:0][IN_W-1:0] r_shadow;
  logic [N_FEAT-1:0][IN_W-1:0] w_shadow_nxt;
  logic [N_FEAT*IN_W-1:0]      r_feat_vec;
  logic                        r_timeout_err;

  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_dec;
  logic             w_tmr_zero;

  logic            w_start_acc;
  logic            w_sample;
  logic            w_timeout;
  logic            w_more;
  logic            w_ch_done;
  logic            w_last;
  logic [IN_W-1:0] w_feat;

  adc_fe_timer #(
    .W (CNT_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

`ifdef OVERSAMPLE_AVG_EN
  logic             r_second;
  logic [ADC_W-1:0] r_s0;
  logic             r_to0;
  logic [ADC_W:0]   w_sum;

  assign w_sum  = {1'b0, r_s0} + {1'b0, i_adc_data};
  assign w_more = ~r_second;
  assign w_feat = (w_timeout | r_to0) ? '0 :
    IN_W'(quantize(RAW_W'(w_sum >> 1), Q_SHIFT));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_second <= 1'b0;
      r_s0     <= '0;
      r_to0    <= 1'b0;
    end else if (w_start_acc) begin
      r_second <= 1'b0;
    end else if (w_sample) begin
      r_second <= ~r_second;
      if (!r_second) begin
        r_s0  <= i_adc_data;
        r_to0 <= w_timeout;
      end
    end
  end
`else
  assign w_more = 1'b0;
  assign w_feat = w_timeout ? '0 :
    IN_W'(quantize(RAW_W'(i_adc_data), Q_SHIFT));
`endif

  assign w_ch_done = w_sample & ~w_more;
  assign w_last    = (r_idx == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = SETTLE_LD;
    w_tmr_dec   = 1'b0;
    w_start_acc = 1'b0;
    w_sample    = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_start_acc = 1'b1;
          w_tmr_load  = 1'b1;
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (w_tmr_zero) begin
          w_state_nxt = CONVERT;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      CONVERT: begin
        w_tmr_load  = 1'b1;
        w_tmr_val   = TO_LD;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // A real answer wins over a timeout landing on the same cycle.
        if (i_adc_done || w_tmr_zero) begin
          w_sample  = 1'b1;
          w_timeout = ~i_adc_done;
          if (w_more) begin
            w_state_nxt = CONVERT;
          end else if (w_last) begin
            w_state_nxt = PRESENT;
          end else begin
            w_tmr_load  = 1'b1;
            w_state_nxt = SETTLE;
          end
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      PRESENT: begin
        if (i_feat_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int i = 0; i < N_FEAT; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_shadow_nxt[i] = w_feat;
      end
    end
  end

  // Output frame only moves on the final channel, so it is double buffered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx         <= '0;
      r_shadow      <= '0;
      r_feat_vec    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_idx         <= '0;
        r_timeout_err <= 1'b0;
      end
      if (w_sample && w_timeout) begin
        r_timeout_err <= 1'b1;
      end
      if (w_ch_done) begin
        r_shadow <= w_shadow_nxt;
        if (w_last) begin
          r_feat_vec <= w_shadow_nxt;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign o_adc_sel     = r_idx;
  assign o_adc_conv    = (r_state == CONVERT);
  assign o_feat_valid  = (r_state == PRESENT);
  assign o_busy        = (r_state != IDLE);
  assign o_feat_vec    = r_feat_vec;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_adc_feature_framer.sv
// Directed bench for adc_feature_framer with an ADC responder model.
// Expected frames are queued at start and popped at feat_valid.
module tb_adc_feature_framer;

  localparam int N_FEAT      = 6;
  localparam int IN_W        = 4;
  localparam int ADC_W       = 8;
  localparam int SETTLE_CYC  = 2;
  localparam int TIMEOUT_CYC = 255;
`ifdef OVERSAMPLE_AVG_EN
  localparam int NCONV = 2;
`else
  localparam int NCONV = 1;
`endif
  localparam int LAT       = 3;
  localparam int FRAME_CYC =
    N_FEAT * (SETTLE_CYC + NCONV * (1 + LAT)) + 1;
  localparam int TO_EXTRA  = NCONV * (TIMEOUT_CYC - LAT);

  typedef struct {
    logic [23:0] vec;
    logic        terr;
    int          lat;
  } exp_t;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [2:0]  o_adc_sel;
  logic        o_adc_conv;
  logic        i_adc_done = 1'b0;
  logic [7:0]  i_adc_data = 8'h00;
  logic [23:0] o_feat_vec;
  logic        o_feat_valid;
  logic        i_feat_ready;
  logic        o_busy;
  logic        o_timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] data0 [0:7];
  logic [7:0] data1 [0:7];
  int         mute        = -1;
  int         spur_req_n  = 0;

  int         spur_done_n = 0;
  int         conv_cnt    = 0;
  logic [2:0] sel_q [$];
  logic       pend        = 1'b0;
  int         cnt         = 0;
  logic [2:0] p_sel       = 3'd0;
  logic       p_phase     = 1'b0;
  logic       phase       = 1'b0;

  exp_t exp_q [$];
  exp_t e;

  adc_feature_framer #(
    .N_FEAT      (N_FEAT),
    .IN_W        (IN_W),
    .ADC_W       (ADC_W),
    .SETTLE_CYC  (SETTLE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .o_adc_sel     (o_adc_sel),
    .o_adc_conv    (o_adc_conv),
    .i_adc_done    (i_adc_done),
    .i_adc_data    (i_adc_data),
    .o_feat_vec    (o_feat_vec),
    .o_feat_valid  (o_feat_valid),
    .i_feat_ready  (i_feat_ready),
    .o_busy        (o_busy),
    .o_timeout_err (o_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model: answers LAT cycles after each conversion pulse.
  always @(negedge clk) begin
    i_adc_done = 1'b0;
    if (i_rst) pend = 1'b0;
    if (!o_busy) phase = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend = 1'b0;
        if (int'(p_sel) != mute) begin
          i_adc_done = 1'b1;
          i_adc_data = p_phase ? data1[p_sel] : data0[p_sel];
        end
      end
    end
    if (spur_req_n != spur_done_n) begin
      spur_done_n = spur_req_n;
      i_adc_done  = 1'b1;
      i_adc_data  = 8'hFF;
    end
    if (o_adc_conv) begin
      conv_cnt++;
      sel_q.push_back(o_adc_sel);
      pend    = 1'b1;
      cnt     = LAT;
      p_sel   = o_adc_sel;
      p_phase = phase;
      if (NCONV == 2) phase = ~phase;
    end
  end

  function automatic logic [23:0] exp_vec();
    logic [23:0] v;
    logic [8:0]  s;
    v = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (NCONV == 2) s = 9'(data0[i]) + 9'(data1[i]);
      else            s = {data0[i], 1'b0};
      v[4*i +: 4] = (i == mute) ? 4'h0 : s[8:5];
    end
    return v;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic expect_frame(input int lat, input logic terr);
    exp_t x;
    x.vec  = exp_vec();
    x.terr = terr;
    x.lat  = lat;
    exp_q.push_back(x);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 1;
    while (!o_feat_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_frame(input string tag, input int n);
    e = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(o_feat_valid), 32'd1);
    chk({tag, "_lat"}, n, e.lat);
    chk({tag, "_vec"}, 32'(o_feat_vec), 32'(e.vec));
    chk({tag, "_terr"}, 32'(o_timeout_err), 32'(e.terr));
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
  endtask

  task automatic handoff();
    i_feat_ready = 1'b1;
    tick(1);
    i_feat_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_valid"}, 32'(o_feat_valid), 32'd0);
    chk({tag, "_conv"}, 32'(o_adc_conv), 32'd0);
    chk({tag, "_sel"}, 32'(o_adc_sel), 32'd0);
    chk({tag, "_terr"}, 32'(o_timeout_err), 32'd0);
    chk({tag, "_vec"}, 32'(o_feat_vec), 32'd0);
  endtask

  initial begin
    int n;
    int m;
    int base_c;
    int base_s;
    i_rst        = 1'b1;
    i_start      = 1'b0;
    i_feat_ready = 1'b0;
    data0[0] = 8'h80; data0[1] = 8'h10; data0[2] = 8'hFF;
    data0[3] = 8'h00; data0[4] = 8'h5A; data0[5] = 8'hC3;
    data0[6] = 8'h00; data0[7] = 8'h00;
    for (int i = 0; i < 8; i++) data1[i] = data0[i];

    tick(3);
    i_rst = 1'b0;
    tick(1);
    check_idle("reset");

    // T1: basic frame
    base_c = conv_cnt;
    base_s = sel_q.size();
    expect_frame(FRAME_CYC, 1'b0);
    start_frame();
    wait_valid(FRAME_CYC + 50, n);
    check_frame("t1", n);
    chk("t1_vec_lit", 32'(o_feat_vec), 32'h00C50F18);
    chk("t1_conv", conv_cnt - base_c, 6 * NCONV);
    for (int k = 0; k < 6 * NCONV; k++)
      chk("t1_sel", 32'(sel_q[base_s + k]), k / NCONV);

    // T2: backpressure, then start on the handoff cycle
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("t2_hold_valid", 32'(o_feat_valid), 32'd1);
      chk("t2_hold_vec", 32'(o_feat_vec), 32'h00C50F18);
    end
    base_c = conv_cnt;
    i_feat_ready = 1'b1;
    i_start      = 1'b1;
    tick(1);
    i_feat_ready = 1'b0;
    i_start      = 1'b0;
    chk("t2_valid_drop", 32'(o_feat_valid), 32'd0);
    chk("t2_busy_drop", 32'(o_busy), 32'd0);
    tick(3);
    chk("t2_start_ignored", 32'(o_busy), 32'd0);
    chk("t2_no_conv", conv_cnt - base_c, 0);

    // T3: channel 2 never answers
    mute = 2;
    expect_frame(FRAME_CYC + TO_EXTRA, 1'b1);
    start_frame();
    wait_valid(FRAME_CYC + TO_EXTRA + 50, n);
    check_frame("t3", n);
    chk("t3_vec_lit", 32'(o_feat_vec), 32'h00C50018);
    handoff();
    chk("t3_terr_sticky", 32'(o_timeout_err), 32'd1);
    mute = -1;

    // T4: reset during the wait of channel 3
    data0[0] = 8'h12; data0[1] = 8'h34; data0[2] = 8'h56;
    data0[3] = 8'h78; data0[4] = 8'h9A; data0[5] = 8'hBC;
    for (int i = 0; i < 8; i++) data1[i] = data0[i];
    start_frame();
    chk("t4_terr_clr", 32'(o_timeout_err), 32'd0);
    n = 0;
    while (!(o_adc_conv && o_adc_sel == 3'd3) && n < 200) begin
      tick(1);
      n++;
    end
    chk("t4_reach_ch3", 32'(o_adc_conv), 32'd1);
    tick(1);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    check_idle("t4_rst");
    tick(LAT + 2);
    expect_frame(FRAME_CYC, 1'b0);
    start_frame();
    wait_valid(FRAME_CYC + 50, n);
    check_frame("t4", n);
    chk("t4_vec_lit", 32'(o_feat_vec), 32'h00B97531);
    handoff();

    // T5: start while busy and spurious done in settle
    data0[0] = 8'hF0; data0[1] = 8'hE1; data0[2] = 8'hD2;
    data0[3] = 8'hC3; data0[4] = 8'hB4; data0[5] = 8'hA5;
    for (int i = 0; i < 8; i++) data1[i] = data0[i];
    base_c = conv_cnt;
    expect_frame(FRAME_CYC, 1'b0);
    start_frame();
    spur_req_n++;
    tick(2);
    i_start = 1'b1;
    tick(3);
    i_start = 1'b0;
    chk("t5_old_vec", 32'(o_feat_vec), 32'h00B97531);
    chk("t5_busy", 32'(o_busy), 32'd1);
    wait_valid(FRAME_CYC + 50, m);
    n = 6 + m - 1;
    check_frame("t5", n);
    chk("t5_vec_lit", 32'(o_feat_vec), 32'h00ABCDEF);
    chk("t5_conv", conv_cnt - base_c, 6 * NCONV);
    handoff();

    // T6: floor on ch0; averaged when oversampling
    data0[0] = 8'h7F;
    data1[0] = 8'h81;
    base_c = conv_cnt;
    expect_frame(FRAME_CYC, 1'b0);
    start_frame();
    wait_valid(FRAME_CYC + 50, n);
    check_frame("t6", n);
    chk("t6_feat0", 32'(o_feat_vec[3:0]), (NCONV == 2) ? 32'h8 : 32'h7);
    chk("t6_conv", conv_cnt - base_c, 6 * NCONV);
    handoff();
    chk("t6_idle", 32'(o_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
